tm1638_ctrl: RTL and testbench
==============================

Name: tm1638_ctrl

Overview:
- Serial master for the TM1638 LED/key board.
- Takes per-digit segment bytes in abcdefgh order and LED bits from the display/counter logic, and continuously refreshes the chip over STB/CLK/DIO.
- Reads the key scan back each frame and presents it as a key vector, the input the key-driven counter logic consumes.
- Sits between the application logic and the board pins.

Parameters:
- clk_mhz, 27: system clock frequency in MHz.
- sclk_khz, 500: TM1638 serial clock frequency in kHz; HALF = clk_mhz*1000/(2*sclk_khz), must be >= 4 (elaboration error otherwise).
- wait_us, 2: DIO turnaround wait after the read command, in microseconds; WAIT = clk_mhz*wait_us cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg_data  in  64  segment byte per digit; seg_data[8*i+:8] is digit i in abcdefgh order (bit7 = a, bit0 = h/dp).
- led  in  8  led[i] lights board LED i.
- brightness  in  3  TM1638 pulse-width setting, 0..7.
- display_on  in  1  display enable.
- key  out  8  debounced-by-frame key state, 1 = pressed.
- key_valid  out  1  one-cycle pulse when key is updated.
- tm_stb  out  1  chip strobe, active low.
- tm_clk  out  1  serial clock, idle high.
- tm_dio_out  out  1  DIO drive value.
- tm_dio_oe  out  1  DIO output enable; the top level builds the tristate.
- tm_dio_in  in  1  DIO pin sample, asynchronous.

Behaviour:
- Reset (synchronous; applies mid-frame too):
  - On the next edge: tm_stb=1, tm_clk=1, tm_dio_oe=0, tm_dio_out=1, key=0, key_valid=0.
  - FSM goes to IDLE and all counters clear.
- Input synchronisation: tm_dio_in passes through a 2-flop synchroniser before use.
- Bit timing:
  - Each bit is tm_clk low for HALF cycles, then high for HALF cycles.
  - tm_dio_out updates on the cycle tm_clk goes low.
  - Bits are sent LSB first.
  - Read bits are sampled from the synchronised DIO on the last cycle of the low phase, i.e. the cycle before tm_clk rises.
- STB timing:
  - tm_stb falls one bit period (2*HALF cycles) before the first tm_clk fall of a transaction.
  - tm_stb rises one bit period after the last tm_clk rise.
  - Minimum tm_stb-high gap between transactions is 2*HALF cycles.
- Frame sequence, FSM IDLE -> T_MODE -> T_DATA -> T_CTRL -> T_RDCMD -> T_WAIT -> T_READ -> DONE -> IDLE:
  - IDLE: wait 2*HALF cycles with stb high, then snapshot seg_data, led, brightness and display_on. Input changes after the snapshot do not affect the current frame.
  - T_MODE: send 0x40 (write, auto-increment), 8 clocks.
  - T_DATA: send 0xC0, then 16 bytes, 136 clocks total.
    - Byte at address 2i is the bit-reversed seg_data digit i: tm_byte[k] = seg[7-k].
    - Byte at address 2i+1 is {7'b0, led[i]}.
  - T_CTRL: send 8'h80 | display_on<<3 | brightness, 8 clocks.
  - T_RDCMD: stb low, send 0x42, 8 clocks; then set tm_dio_oe=0 on the cycle after the last tm_clk rise.
  - T_WAIT: hold tm_clk high and stb low for WAIT cycles.
  - T_READ: 32 clocks, reading bytes b0..b3 LSB first; then stb high.
  - DONE:
    - key[i] = b_i[0] for i = 0..3.
    - key[i+4] = b_i[4] for i = 0..3.
    - key and key_valid=1 are registered in the same cycle; key_valid lasts one cycle.
    - FSM returns to IDLE.
- tm_dio_oe is 1 from the first tm_stb fall of the frame until T_RDCMD ends, and 0 in T_WAIT, T_READ, DONE and IDLE.
- key holds its value between frames; only reset clears it.

Test Plan:
- Reset: hold rst 3 cycles mid-T_DATA -> next edge tm_stb=1, tm_clk=1, tm_dio_oe=0, key=0. After release, the first tm_stb fall occurs 2*HALF cycles later and the first byte is 0x40.
- Mode byte: default params (HALF=27) -> tm_clk low/high phases are exactly 27 cycles each. The first stb-low window contains 8 rising edges carrying 0,0,0,0,0,0,1,0 (0x40 LSB first).
- Data mapping: seg_data digit0 = 8'b1111_1100, led = 8'h01, others 0 -> address 0 byte 0x3F, address 1 byte 0x01, remaining 14 bytes 0x00. The transaction has 136 clocks.
- Control byte: brightness=7, display_on=1 -> 0x8F; brightness=2, display_on=0 -> 0x82.
- Key read: bus model drives b0..b3 = 0x01, 0x00, 0x10, 0x00 after oe drops -> key=8'h41 with a single-cycle key_valid pulse. No tm_clk edge occurs during the WAIT cycles, and tm_dio_oe=0 throughout.
- Snapshot: change seg_data during T_DATA -> the current frame sends the old bytes and the next frame sends the new bytes.

Source files
------------

// File: rtl/tm1638_if.sv
// Pin-level bus between the TM1638 serial master and the LED/key board.
interface tm1638_if;
    logic tm_stb;
    logic tm_clk;
    logic tm_dio_out;
    logic tm_dio_oe;
    logic tm_dio_in;

    modport master (
        output tm_stb, tm_clk, tm_dio_out, tm_dio_oe,
        input  tm_dio_in
    );
    modport slave (
        input  tm_stb, tm_clk, tm_dio_out, tm_dio_oe,
        output tm_dio_in
    );
endinterface

// File: rtl/tm1638_ctrl.sv
// TM1638 serial master: refreshes digits/LEDs every frame and reads the key scan back.
//   state   | meaning
//   IDLE    | stb-high gap before the frame, snapshot inputs at its end
//   T_MODE  | send 0x40 (write, auto-increment)
//   T_DATA  | send 0xC0 followed by 16 display bytes
//   T_CTRL  | send display control byte
//   T_RDCMD | send 0x42, release DIO after the last clock rise
//   T_WAIT  | DIO turnaround, tm_clk held high
//   T_READ  | clock in 4 key-scan bytes
//   DONE    | publish key vector with key_valid pulse
module tm1638_ctrl #(
    parameter int clk_mhz  = 27,
    parameter int sclk_khz = 500,
    parameter int wait_us  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] seg_data,
    input  logic [7:0]  led,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic [7:0]  key,
    output logic        key_valid,
    tm1638_if.master    tm
);
    localparam int HALF = clk_mhz * 1000 / (2 * sclk_khz);
    localparam int WAIT = clk_mhz * wait_us;
    localparam logic [15:0] HALF_TC = 16'(HALF - 1);
    localparam logic [15:0] BIT_TC  = 16'(2 * HALF - 1);
    localparam logic [15:0] WAIT_TC = 16'(WAIT - 1);
    localparam logic [7:0]  CMD_MODE = 8'h40;
    localparam logic [7:0]  CMD_ADDR = 8'hC0;
    localparam logic [7:0]  CMD_READ = 8'h42;

    generate
        if (HALF < 4) begin : g_half_chk
            $error("tm1638_ctrl: serial half period must be at least 4 clk cycles");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, T_MODE, T_DATA, T_CTRL, T_RDCMD, T_WAIT, T_READ, DONE} state_t;
    typedef enum logic [2:0] {PH_GAP, PH_PRE, PH_LOW, PH_HIGH, PH_POST} phase_t;

    state_t      state, state_nxt;
    phase_t      phase, phase_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  bit_idx, bit_nxt;
    logic        stb_q, clk_q, oe_q, dout_q;
    logic        stb_nxt, clk_nxt, oe_nxt, dout_nxt;
    logic        snap_en, sample_en, key_load;
    logic [63:0] seg_snap;
    logic [7:0]  led_snap;
    logic [7:0]  ctrl_byte;
    logic [7:0]  rx_key;
    logic        dio_meta, dio_sync;
    logic [7:0]  tx_idx;
    logic [3:0]  addr;
    logic        tx_bit;
    logic        last_bit;

    assign tm.tm_stb     = stb_q;
    assign tm.tm_clk     = clk_q;
    assign tm.tm_dio_oe  = oe_q;
    assign tm.tm_dio_out = dout_q;

    always_ff @(posedge clk) begin
        dio_meta <= tm.tm_dio_in;
        dio_sync <= dio_meta;
    end

    always_ff @(posedge clk) begin
        if (snap_en) begin
            seg_snap  <= seg_data;
            led_snap  <= led;
            ctrl_byte <= {4'b1000, display_on, brightness};
        end
    end

    always_comb begin
        unique case (state)
            T_DATA:  last_bit = (bit_idx == 8'd135);
            T_READ:  last_bit = (bit_idx == 8'd31);
            default: last_bit = (bit_idx == 8'd7);
        endcase
    end

    // Bit to drive on the next tm_clk fall: the current bit from the preamble, otherwise the following one.
    always_comb begin
        tx_idx = (phase == PH_PRE) ? bit_idx : bit_idx + 8'd1;
        addr   = tx_idx[6:3] - 4'd1;
        tx_bit = 1'b1;
        case (state)
            T_MODE:  tx_bit = CMD_MODE[tx_idx[2:0]];
            T_DATA: begin
                if (tx_idx[7:3] == 5'd0)
                    tx_bit = CMD_ADDR[tx_idx[2:0]];
                else if (!addr[0])
                    tx_bit = seg_snap[{addr[3:1], ~tx_idx[2:0]}];
                else
                    tx_bit = (tx_idx[2:0] == 3'd0) && led_snap[addr[3:1]];
            end
            T_CTRL:  tx_bit = ctrl_byte[tx_idx[2:0]];
            T_RDCMD: tx_bit = CMD_READ[tx_idx[2:0]];
            default: tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt + 16'd1;
        bit_nxt   = bit_idx;
        stb_nxt   = stb_q;
        clk_nxt   = clk_q;
        oe_nxt    = oe_q;
        dout_nxt  = dout_q;
        snap_en   = 1'b0;
        sample_en = 1'b0;
        key_load  = 1'b0;
        if (state == T_WAIT) begin
            if (cnt == WAIT_TC) begin
                cnt_nxt   = '0;
                state_nxt = T_READ;
                phase_nxt = PH_LOW;
                bit_nxt   = '0;
                clk_nxt   = 1'b0;
                dout_nxt  = 1'b1;
            end
        end else if (state == DONE) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            phase_nxt = PH_GAP;
        end else begin
            unique case (phase)
                PH_GAP: if (cnt == BIT_TC) begin
                    cnt_nxt   = '0;
                    phase_nxt = PH_PRE;
                    stb_nxt   = 1'b0;
                    oe_nxt    = 1'b1;
                    bit_nxt   = '0;
                    if (state == IDLE) begin
                        state_nxt = T_MODE;
                        snap_en   = 1'b1;
                    end
                end
                PH_PRE: if (cnt == BIT_TC) begin
                    cnt_nxt   = '0;
                    phase_nxt = PH_LOW;
                    clk_nxt   = 1'b0;
                    dout_nxt  = tx_bit;
                end
                PH_LOW: if (cnt == HALF_TC) begin
                    cnt_nxt   = '0;
                    phase_nxt = PH_HIGH;
                    clk_nxt   = 1'b1;
                    sample_en = (state == T_READ);
                end
                PH_HIGH: begin
                    if (state == T_RDCMD && last_bit && cnt == 16'd0)
                        oe_nxt = 1'b0;
                    if (cnt == HALF_TC) begin
                        cnt_nxt = '0;
                        if (!last_bit) begin
                            bit_nxt   = bit_idx + 8'd1;
                            phase_nxt = PH_LOW;
                            clk_nxt   = 1'b0;
                            dout_nxt  = tx_bit;
                        end else if (state == T_RDCMD) begin
                            state_nxt = T_WAIT;
                        end else begin
                            phase_nxt = PH_POST;
                        end
                    end
                end
                PH_POST: if (cnt == HALF_TC) begin
                    cnt_nxt   = '0;
                    stb_nxt   = 1'b1;
                    phase_nxt = PH_GAP;
                    case (state)
                        T_MODE:  state_nxt = T_DATA;
                        T_DATA:  state_nxt = T_CTRL;
                        T_CTRL:  state_nxt = T_RDCMD;
                        default: begin
                            state_nxt = DONE;
                            key_load  = 1'b1;
                        end
                    endcase
                end
                default: phase_nxt = PH_GAP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= PH_GAP;
            cnt       <= '0;
            bit_idx   <= '0;
            stb_q     <= 1'b1;
            clk_q     <= 1'b1;
            oe_q      <= 1'b0;
            dout_q    <= 1'b1;
            rx_key    <= '0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            stb_q     <= stb_nxt;
            clk_q     <= clk_nxt;
            oe_q      <= oe_nxt;
            dout_q    <= dout_nxt;
            key_valid <= key_load;
            if (key_load)
                key <= rx_key;
            // Only bits 0 and 4 of each scan byte carry keys.
            if (sample_en && bit_idx[2:0] == 3'd0)
                rx_key[{1'b0, bit_idx[4:3]}] <= dio_sync;
            if (sample_en && bit_idx[2:0] == 3'd4)
                rx_key[{1'b1, bit_idx[4:3]}] <= dio_sync;
        end
    end
endmodule

// File: tb/tb_tm1638_ctrl.sv
// Directed bench for tm1638_ctrl: pin-level monitor plus key-scan responder.
module tb_tm1638_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] seg_data;
    logic [7:0]  led;
    logic [2:0]  brightness;
    logic        display_on;
    logic [7:0]  key;
    logic        key_valid;

    tm1638_if bus ();

    tm1638_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .led        (led),
        .brightness (brightness),
        .display_on (display_on),
        .key        (key),
        .key_valid  (key_valid),
        .tm         (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int ts = 0;
    logic prev_stb = 1'b1, prev_clk = 1'b1, prev_oe = 1'b0, prev_kv = 1'b0;
    int t_stb_f = 0, t_fall = 0, t_rise = 0;
    logic first_fall = 1'b0, oe_dropped = 1'b0;
    logic [135:0] cur_bits = '0;
    int cur_n = 0, rd_idx = 0;
    logic [31:0] rd_data;
    int lo_min = 1000000, lo_max = 0, hi_min = 1000000, hi_max = 0;
    int wait_len = -1, oe_lag = -1, oe_high_in_read = 0;
    int kv_cnt = 0, kv_run = 0, kv_maxrun = 0;
    int q_n[$];
    logic [135:0] q_bits[$];
    int q_pre[$];
    int q_post[$];

    // Pin monitor and board responder, sampled on the falling system clock edge.
    always @(negedge clk) begin
        ts++;
        if (prev_stb && !bus.tm_stb) begin
            t_stb_f = ts; cur_n = 0; cur_bits = '0;
            first_fall = 1'b1; rd_idx = 0; oe_dropped = 1'b0;
        end
        if (!bus.tm_stb) begin
            if (prev_clk && !bus.tm_clk) begin
                if (first_fall) begin
                    q_pre.push_back(ts - t_stb_f);
                    first_fall = 1'b0;
                end else if (oe_dropped && rd_idx == 0) begin
                    wait_len = ts - t_rise;
                end else begin
                    if (ts - t_rise < hi_min) hi_min = ts - t_rise;
                    if (ts - t_rise > hi_max) hi_max = ts - t_rise;
                end
                t_fall = ts;
                if (!bus.tm_dio_oe && rd_idx < 32) begin
                    bus.tm_dio_in = rd_data[rd_idx];
                    rd_idx++;
                end
            end
            if (!prev_clk && bus.tm_clk) begin
                if (ts - t_fall < lo_min) lo_min = ts - t_fall;
                if (ts - t_fall > lo_max) lo_max = ts - t_fall;
                t_rise = ts;
                if (cur_n < 136) cur_bits[cur_n] = bus.tm_dio_out;
                cur_n++;
            end
            if (prev_oe && !bus.tm_dio_oe) begin
                oe_dropped = 1'b1;
                oe_lag = ts - t_rise;
            end
            if (oe_dropped && bus.tm_dio_oe) oe_high_in_read++;
        end else begin
            bus.tm_dio_in = 1'b1;
        end
        if (!prev_stb && bus.tm_stb) begin
            q_n.push_back(cur_n);
            q_bits.push_back(cur_bits);
            q_post.push_back(ts - t_rise);
        end
        if (key_valid) kv_run++; else kv_run = 0;
        if (kv_run > kv_maxrun) kv_maxrun = kv_run;
        if (key_valid && !prev_kv) kv_cnt++;
        prev_stb = bus.tm_stb;
        prev_clk = bus.tm_clk;
        prev_oe  = bus.tm_dio_oe;
        prev_kv  = key_valid;
    end

    task automatic chk_i(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_txn(input int k);
        int c = 0;
        while (q_n.size() < k && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        chk_i("txn_timeout", int'(q_n.size() >= k), 1);
    endtask

    task automatic wait_kv(input int k);
        int c = 0;
        while (kv_cnt < k && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        chk_i("key_valid_timeout", int'(kv_cnt >= k), 1);
    endtask

    task automatic wait_stb_low(output int n);
        n = 0;
        while (bus.tm_stb && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk_i({tag, "_stb"}, int'(bus.tm_stb), 1);
        chk_i({tag, "_clk"}, int'(bus.tm_clk), 1);
        chk_i({tag, "_oe"},  int'(bus.tm_dio_oe), 0);
        chk_i({tag, "_dout"}, int'(bus.tm_dio_out), 1);
        chk_i({tag, "_key"}, int'(key), 0);
        chk_i({tag, "_kv"},  int'(key_valid), 0);
    endtask

    initial begin
        logic [135:0] exp_a, exp_b, tmp;
        int n;

        exp_a = '0;
        exp_a[7:0]   = 8'hC0;
        exp_a[15:8]  = 8'h3F;
        exp_a[23:16] = 8'h01;
        exp_b = '0;
        exp_b[7:0]     = 8'hC0;
        exp_b[63:56]   = 8'h83;
        exp_b[127:120] = 8'h70;
        exp_b[135:128] = 8'h01;

        rst = 1'b1;
        seg_data = 64'h0000_0000_0000_00FC;
        led = 8'h01;
        brightness = 3'd7;
        display_on = 1'b1;
        rd_data = 32'h0010_0001;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst = 1'b0;
        wait_stb_low(n);
        chk_i("por_stb_fall_delay", n, 54);

        // Frame A: change inputs while its data transaction is in flight.
        wait_txn(1);
        wait_stb_low(n);
        repeat (100) @(posedge clk);
        #1;
        seg_data = 64'h0E00_0000_C100_0000;
        led = 8'h80;
        brightness = 3'd2;
        display_on = 1'b0;
        wait_txn(4);
        wait_kv(1);
        chk_i("mode_nclk", q_n[0], 8);
        tmp = q_bits[0];
        chk_v("mode_byte", {128'd0, tmp[7:0]}, 136'h40);
        chk_i("mode_stb_to_clk", q_pre[0], 54);
        chk_i("mode_clk_to_stb", q_post[0], 54);
        chk_i("dataA_nclk", q_n[1], 136);
        chk_v("dataA_bytes", q_bits[1], exp_a);
        chk_i("ctrlA_nclk", q_n[2], 8);
        tmp = q_bits[2];
        chk_v("ctrlA_byte", {128'd0, tmp[7:0]}, 136'h8F);
        chk_i("rdA_nclk", q_n[3], 40);
        tmp = q_bits[3];
        chk_v("rdcmd_byte", {128'd0, tmp[7:0]}, 136'h42);
        chk_i("oe_drop_after_rise", oe_lag, 1);
        chk_i("wait_clk_high", wait_len, 81);
        chk_i("oe_during_read", oe_high_in_read, 0);
        chk_i("keyA", int'(key), 8'h41);
        chk_i("key_valid_width", kv_maxrun, 1);

        // Frame B: new snapshot and a different key pattern.
        rd_data = 32'h1290_2111;
        wait_txn(8);
        wait_kv(2);
        chk_i("dataB_nclk", q_n[5], 136);
        chk_v("dataB_bytes", q_bits[5], exp_b);
        tmp = q_bits[6];
        chk_v("ctrlB_byte", {128'd0, tmp[7:0]}, 136'h82);
        chk_i("keyB", int'(key), 8'hD3);
        chk_i("key_valid_count", kv_cnt, 2);
        chk_i("key_valid_width_b", kv_maxrun, 1);

        // Frame C: reset in the middle of the data transaction.
        wait_txn(9);
        wait_stb_low(n);
        repeat (200) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_stb_low(n);
        chk_i("mid_stb_fall_delay", n, 54);
        q_n.delete();
        q_bits.delete();
        wait_txn(1);
        chk_i("post_rst_nclk", q_n[0], 8);
        tmp = q_bits[0];
        chk_v("post_rst_byte", {128'd0, tmp[7:0]}, 136'h40);

        chk_i("clk_low_min", lo_min, 27);
        chk_i("clk_low_max", lo_max, 27);
        chk_i("clk_high_min", hi_min, 27);
        chk_i("clk_high_max", hi_max, 27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
